alu_mul_seq: RTL and testbench

Multi-cycle shift-and-add multiplier sequencer that produces the low ARCH bits of a product using the core's single-cycle ALU. It sits beside the execute stage and owns the ALU operand and control inputs while a multiply is in flight. It issues one ADD or SLL operation per cycle and captures each ALU result into internal registers. This provides RV32M MUL semantics without adding a dedicated multiplier array.

---
 rtl/friscv_pkg.sv | 17 +
 rtl/alu_mul_seq.sv | 150 +++++++++++++++
 tb/tb_alu_mul_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/friscv_pkg.sv
// Shared core definitions: datapath width, ALU op encodings and multiply sequencer states.
package friscv_pkg;

    localparam int unsigned ARCH      = 32;
    localparam int unsigned MUL_CNT_W = $clog2(ARCH);

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SLL = 4'h1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ADD_ST   = 2'd1,
        SHIFT_ST = 2'd2,
        DONE_ST  = 2'd3
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the core ALU; yields the low ARCH bits of a*b.
// Define MUL_EARLY_TERM_EN to stop as soon as the remaining multiplier is zero.
module alu_mul_seq #(
    parameter int unsigned ARCH = friscv_pkg::ARCH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_in,
    input  logic [ARCH-1:0] a_in,
    input  logic [ARCH-1:0] b_in,
    output logic            busy_out,
    output logic            done_out,
    output logic [ARCH-1:0] result_out,
    output logic [3:0]      alu_ctrl_out,
    output logic [ARCH-1:0] alu_a_out,
    output logic [ARCH-1:0] alu_b_out,
    input  logic [ARCH-1:0] alu_result_in
);
    import friscv_pkg::*;

    localparam int unsigned CNT_W = $clog2(ARCH);

    mul_state_t      state_q, state_d;
    logic [ARCH-1:0] acc_q, acc_d;
    logic [ARCH-1:0] mcand_q, mcand_d;
    logic [ARCH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ARCH-1:0] result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [3:0]      alu_ctrl_q, alu_ctrl_d;
    logic [ARCH-1:0] alu_a_q, alu_a_d;
    logic [ARCH-1:0] alu_b_q, alu_b_d;

    // Next state and datapath updates
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    acc_d    = '0;
                    mcand_d  = a_in;
                    mplier_d = b_in;
                    count_d  = '0;
                    state_d  = b_in[0] ? ADD_ST : SHIFT_ST;
`ifdef MUL_EARLY_TERM_EN
                    if (b_in == '0) begin
                        state_d = DONE_ST;
                    end
`endif
                end
            end
            ADD_ST: begin
                acc_d   = alu_result_in;
                state_d = SHIFT_ST;
            end
            SHIFT_ST: begin
                mcand_d  = alu_result_in;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_W'(ARCH - 1)) begin
                    state_d = DONE_ST;
`ifdef MUL_EARLY_TERM_EN
                end else if (mplier_q[ARCH-1:1] == '0) begin
                    state_d = DONE_ST;
`endif
                end else if (mplier_q[1]) begin
                    state_d = ADD_ST;
                end else begin
                    state_d = SHIFT_ST;
                end
            end
            DONE_ST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DONE_ST) begin
            result_d = acc_d;
        end
    end

    // Outputs are precomputed from the next state so they leave the block registered
    always_comb begin
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE_ST);
        alu_ctrl_d = ALU_ADD;
        alu_a_d    = '0;
        alu_b_d    = '0;
        case (state_d)
            ADD_ST: begin
                alu_a_d = acc_d;
                alu_b_d = mcand_d;
            end
            SHIFT_ST: begin
                alu_ctrl_d = ALU_SLL;
                alu_a_d    = mcand_d;
                alu_b_d    = ARCH'(1);
            end
            default: begin
                alu_ctrl_d = ALU_ADD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            count_q    <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            alu_ctrl_q <= ALU_ADD;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            count_q    <= count_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            alu_ctrl_q <= alu_ctrl_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
        end
    end

    assign busy_out     = busy_q;
    assign done_out     = done_q;
    assign result_out   = result_q;
    assign alu_ctrl_out = alu_ctrl_q;
    assign alu_a_out    = alu_a_q;
    assign alu_b_out    = alu_b_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: supplies the ALU, predicts busy/done/result from the product and latency rules.
module tb_alu_mul_seq;
    import friscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic [31:0] a_in, b_in;
    logic        busy_out, done_out;
    logic [31:0] result_out;
    logic [3:0]  alu_ctrl_out;
    logic [31:0] alu_a_out, alu_b_out, alu_result_in;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    alu_mul_seq #(.ARCH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_in     (start_in),
        .a_in         (a_in),
        .b_in         (b_in),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .result_out   (result_out),
        .alu_ctrl_out (alu_ctrl_out),
        .alu_a_out    (alu_a_out),
        .alu_b_out    (alu_b_out),
        .alu_result_in(alu_result_in)
    );

    always #5 clk = ~clk;

    // Reference single-cycle ALU
    always_comb begin
        alu_result_in = '0;
        if (alu_ctrl_out == ALU_ADD) alu_result_in = alu_a_out + alu_b_out;
        else if (alu_ctrl_out == ALU_SLL) alu_result_in = alu_a_out << alu_b_out[4:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Edges between the accept edge and the edge that enters DONE
    function automatic int lat_of(input logic [31:0] b);
        int pop;
        int msb;
        pop = $countones(b);
`ifdef MUL_EARLY_TERM_EN
        if (b == 32'd0) return 0;
        msb = 0;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        return msb + 1 + pop;
`else
        msb = 0;
        return 32 + pop + msb;
`endif
    endfunction

    // Transaction model: product and handshake timing only
    logic        m_busy, m_done;
    logic [31:0] m_result, m_prod;
    int          m_rem;

    always @(posedge clk) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_result <= '0;
            m_rem    <= 0;
        end else if (m_done) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else if (m_busy) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_done   <= 1'b1;
                m_result <= m_prod;
            end
        end else if (start_in) begin
            m_busy <= 1'b1;
            m_prod <= a_in * b_in;
            m_rem  <= lat_of(b_in);
            if (lat_of(b_in) == 0) begin
                m_done   <= 1'b1;
                m_result <= a_in * b_in;
            end
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy_out), 32'(m_busy));
            check("done", 32'(done_out), 32'(m_done));
            check("result", result_out, m_result);
            if (!m_busy || m_done) begin
                check("idle_alu_ctrl", 32'(alu_ctrl_out), 32'(ALU_ADD));
                check("idle_alu_a", alu_a_out, 32'd0);
                check("idle_alu_b", alu_b_out, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy_out !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 300), 32'd1);
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input int exp_lat);
        int lat;
        lat = 0;
        wait_idle();
        a_in = a; b_in = b; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        while (done_out !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("product", result_out, exp_res);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ndone;
        rst = 1'b1; start_in = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_result", result_out, 32'd0);
        check("rst_ctrl", 32'(alu_ctrl_out), 32'(ALU_ADD));
        @(negedge clk);
        rst = 1'b0;

`ifdef MUL_EARLY_TERM_EN
        run_mul(32'd6, 32'd7, 32'd42, 6);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 64);
        run_mul(32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 5);
        run_mul(32'h12345678, 32'd0, 32'd0, 0);
`else
        run_mul(32'd6, 32'd7, 32'd42, 35);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 64);
        run_mul(32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 34);
        run_mul(32'h12345678, 32'd0, 32'd0, 32);
`endif

        // start held high with changing operands while busy
        wait_idle();
        a_in = 32'd5; b_in = 32'd9; start_in = 1'b1;
        ndone = 0;
        for (int i = 0; i < 300 && ndone == 0; i++) begin
            @(negedge clk);
            if (done_out === 1'b1) ndone++;
            else begin
                a_in = $urandom;
                b_in = $urandom;
            end
        end
        check("held_done_seen", 32'(ndone), 32'd1);
        check("held_product", result_out, 32'd45);
        a_in = 32'd7; b_in = 32'd11;
        @(negedge clk);
        check("held_single_pulse", 32'(done_out), 32'd0);
        check("held_idle_after_done", 32'(busy_out), 32'd0);
        @(posedge clk); #1;
        start_in = 1'b0;
        check("held_reaccept", 32'(busy_out), 32'd1);
        ndone = 0;
        for (int i = 0; i < 300 && ndone == 0; i++) begin
            @(negedge clk);
            if (done_out === 1'b1) ndone++;
        end
        check("held_second_done", 32'(ndone), 32'd1);
        check("held_second_product", result_out, 32'd77);

        // reset in the middle of a multiply
        wait_idle();
        a_in = 32'd3; b_in = 32'h80000001; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy_out), 32'd0);
        check("abort_done", 32'(done_out), 32'd0);
        check("abort_result", result_out, 32'd0);
        check("abort_ctrl", 32'(alu_ctrl_out), 32'(ALU_ADD));
        check("abort_alu_a", alu_a_out, 32'd0);
        check("abort_alu_b", alu_b_out, 32'd0);
        ndone = 0;
        repeat (80) begin
            @(negedge clk);
            if (done_out === 1'b1) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
`ifdef MUL_EARLY_TERM_EN
        run_mul(32'd2, 32'd3, 32'd6, 4);
`else
        run_mul(32'd2, 32'd3, 32'd6, 34);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
